// File: rtl/subleq_mem_responder_if.sv
// subleq_mem_responder_if: bus bundle between the SUBLEQ control unit / program
// loader (master) and the memory responder (slave). clk and res are not part
// of the bundle.
interface subleq_mem_responder_if #(
    parameter int ADR_W = 8,
    parameter int DAT_W = 8
) ();
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat_in;
    logic [DAT_W-1:0] dat_out;
    logic             dat_oe;
    logic             ram_ena;
    logic             ram_ope;
    logic             ram_ctl;
    logic             rd_valid;
    logic             ld_start;
    logic             ld_valid;
    logic             ld_ready;
    logic             ld_last;
    logic [DAT_W-1:0] ld_data;
    logic             busy;
    logic             bus_err;
    logic             par_err;

    modport master (
        output adr, dat_in, ram_ena, ram_ope, ram_ctl,
        output ld_start, ld_valid, ld_last, ld_data,
        input  dat_out, dat_oe, rd_valid, ld_ready, busy, bus_err, par_err
    );

    modport slave (
        input  adr, dat_in, ram_ena, ram_ope, ram_ctl,
        input  ld_start, ld_valid, ld_last, ld_data,
        output dat_out, dat_oe, rd_valid, ld_ready, busy, bus_err, par_err
    );
endinterface

// File: rtl/subleq_mem_responder.sv
// subleq_mem_responder: memory-side responder for the SUBLEQ machine bus.
// Serves reads after READ_LAT cycles (legal 1..7), commits writes, and owns a
// program-loader port that fills memory from address 0 upwards.
// Optional feature macro: SUBLEQ_MEM_PARITY_EN -- each word carries an extra
// even-parity bit written on every store and checked on every read.
module subleq_mem_responder #(
    parameter int ADR_W    = 8,
    parameter int DAT_W    = 8,
    parameter int READ_LAT = 2
) (
    input  logic                 clk,
    input  logic                 res,
    subleq_mem_responder_if.slave bus
);

`ifdef SUBLEQ_MEM_PARITY_EN
    localparam int MEM_W = DAT_W + 1;
`else
    localparam int MEM_W = DAT_W;
`endif

    // Counter starts at READ_LAT-1 so data appears READ_LAT edges after the request edge.
    localparam logic [2:0] CNT_RELOAD = 3'(READ_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        WR,
        LOAD
    } state_t;

    state_t state;
    state_t state_next;

    logic [MEM_W-1:0] mem [0:(2**ADR_W)-1];

    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat_in;
    logic [DAT_W-1:0] ld_data;
    logic             ram_ena;
    logic             ram_ope;
    logic             ram_ctl;
    logic             ld_start;
    logic             ld_valid;
    logic             ld_last;

    logic [ADR_W-1:0] adr_q;
    logic [ADR_W-1:0] ptr;
    logic [2:0]       cnt;
    logic [DAT_W-1:0] dat_out_q;
    logic             dat_oe_q;
    logic             rd_valid_q;
    logic             bus_err_q;
    logic             par_err_q;

    logic             wr_req;
    logic             rd_req;
    logic             wr_en;
    logic [ADR_W-1:0] wr_adr;
    logic [DAT_W-1:0] wr_dat;
    logic [MEM_W-1:0] wr_word;
    logic [MEM_W-1:0] rd_word;
    logic             capture;
    logic             cnt_dec;
    logic             read_now;
    logic             oe_next;
    logic             ptr_step;
    logic             ptr_clear;
    logic             conflict;

    assign adr      = bus.adr;
    assign dat_in   = bus.dat_in;
    assign ld_data  = bus.ld_data;
    assign ram_ena  = bus.ram_ena;
    assign ram_ope  = bus.ram_ope;
    assign ram_ctl  = bus.ram_ctl;
    assign ld_start = bus.ld_start;
    assign ld_valid = bus.ld_valid;
    assign ld_last  = bus.ld_last;

    // Control strobes are active-low and only count while the chip is enabled.
    assign wr_req = !ram_ena && !ram_ctl;
    assign rd_req = !ram_ena && !ram_ope;

`ifdef SUBLEQ_MEM_PARITY_EN
    assign wr_word = {^wr_dat, wr_dat};
`else
    assign wr_word = wr_dat;
`endif

    assign rd_word = mem[adr_q];

    // Next-state and strobe decode; a write request always beats a read request.
    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_adr     = adr;
        wr_dat     = dat_in;
        capture    = 1'b0;
        cnt_dec    = 1'b0;
        read_now   = 1'b0;
        oe_next    = 1'b0;
        ptr_step   = 1'b0;
        ptr_clear  = 1'b0;
        conflict   = 1'b0;
        if (state == LOAD) begin
            if (ld_valid) begin
                wr_en    = 1'b1;
                wr_adr   = ptr;
                wr_dat   = ld_data;
                ptr_step = 1'b1;
                if (ld_last) begin
                    ptr_clear  = 1'b1;
                    state_next = IDLE;
                end
            end
        end else if (wr_req) begin
            wr_en      = 1'b1;
            conflict   = rd_req;
            state_next = WR;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req) begin
                        capture    = 1'b1;
                        state_next = RD_WAIT;
                    end else if (ld_start) begin
                        state_next = LOAD;
                    end
                end
                WR: begin
                    if (rd_req) begin
                        capture    = 1'b1;
                        state_next = RD_WAIT;
                    end else begin
                        state_next = IDLE;
                    end
                end
                RD_WAIT: begin
                    if (!rd_req) begin
                        state_next = IDLE;
                    end else if (cnt == 3'd0) begin
                        read_now   = 1'b1;
                        oe_next    = 1'b1;
                        state_next = RD_DRIVE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
                RD_DRIVE: begin
                    if (!rd_req) begin
                        state_next = IDLE;
                    end else if (adr != adr_q) begin
                        capture    = 1'b1;
                        state_next = RD_WAIT;
                    end else begin
                        oe_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (res) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read address latch and latency counter.
    always_ff @(posedge clk) begin
        if (res) begin
            adr_q <= '0;
            cnt   <= 3'd0;
        end else if (capture) begin
            adr_q <= adr;
            cnt   <= CNT_RELOAD;
        end else if (cnt_dec) begin
            cnt <= cnt - 3'd1;
        end
    end

    // Loader pointer: advances per accepted beat and restarts at 0 after the last word.
    always_ff @(posedge clk) begin
        if (res) begin
            ptr <= '0;
        end else if (ptr_clear) begin
            ptr <= '0;
        end else if (ptr_step) begin
            ptr <= ptr + 1'b1;
        end
    end

    // Registered read outputs and the sticky bus-conflict flag.
    always_ff @(posedge clk) begin
        if (res) begin
            dat_out_q  <= '0;
            dat_oe_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            dat_oe_q   <= oe_next;
            rd_valid_q <= read_now;
            bus_err_q  <= bus_err_q | conflict;
            if (read_now) begin
                dat_out_q <= rd_word[DAT_W-1:0];
            end
        end
    end

    // Memory array; contents survive reset, but a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (wr_en && !res) begin
            mem[wr_adr] <= wr_word;
        end
    end

`ifdef SUBLEQ_MEM_PARITY_EN
    // Sticky parity error: stored word plus parity bit must XOR to zero.
    always_ff @(posedge clk) begin
        if (res) begin
            par_err_q <= 1'b0;
        end else if (read_now && (^rd_word)) begin
            par_err_q <= 1'b1;
        end
    end
`else
    assign par_err_q = 1'b0;
`endif

    assign bus.dat_out  = dat_out_q;
    assign bus.dat_oe   = dat_oe_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.ld_ready = (state == LOAD);
    assign bus.busy     = (state == LOAD);
    assign bus.bus_err  = bus_err_q;
    assign bus.par_err  = par_err_q;

endmodule

// File: tb/tb_subleq_mem_responder.sv
// tb_subleq_mem_responder: directed bench for subleq_mem_responder. Read
// requests push their expected word and arrival cycle into a queue; a monitor
// pops and compares on every rd_valid pulse.
module tb_subleq_mem_responder;
    localparam int ADR_W    = 8;
    localparam int DAT_W    = 8;
    localparam int READ_LAT = 2;

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic res;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    subleq_mem_responder_if #(.ADR_W(ADR_W), .DAT_W(DAT_W)) bus ();

    subleq_mem_responder #(
        .ADR_W(ADR_W),
        .DAT_W(DAT_W),
        .READ_LAT(READ_LAT)
    ) dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    // Free-running clock and cycle counter used for latency bookkeeping.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every rd_valid pulse must match the oldest outstanding read.
    always @(negedge clk) begin
        if (res === 1'b0 && bus.rd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_read actual=%h required=no_read", bus.dat_out);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.dat_out !== mon_e.data || cyc != mon_e.due || bus.dat_oe !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL read_response actual=%h@%0d oe=%b required=%h@%0d oe=1",
                             bus.dat_out, cyc, bus.dat_oe, mon_e.data, mon_e.due);
                end
            end
        end
    end

    // Watchdog so the bench always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string name, input logic actual, input logic required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%b required=%b", name, actual, required);
        end
    endtask

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic apply_stimulus(input logic ena, input logic ope, input logic ctl,
                                  input logic [7:0] a, input logic [7:0] d);
        bus.ram_ena = ena;
        bus.ram_ope = ope;
        bus.ram_ctl = ctl;
        bus.adr     = a;
        bus.dat_in  = d;
    endtask

    task automatic expect_read(input logic [7:0] d);
        exp_t e;
        e.data = d;
        e.due  = cyc + 1 + READ_LAT;
        exp_q.push_back(e);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] d, input logic with_ld);
        apply_stimulus(1'b0, 1'b0, 1'b1, a, 8'h00);
        bus.ld_start = with_ld;
        expect_read(d);
        step();
        bus.ld_start = 1'b0;
        if (with_ld) check_bit("ld_start_ignored_busy", bus.busy, 1'b0);
        repeat (READ_LAT) step();
        check_bit("read_dat_oe", bus.dat_oe, 1'b1);
        apply_stimulus(1'b1, 1'b1, 1'b1, a, 8'h00);
        step();
        check_bit("read_release_dat_oe", bus.dat_oe, 1'b0);
    endtask

    task automatic load_word(input logic [7:0] d, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_data  = d;
        bus.ld_last  = last;
        step();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic start_load();
        bus.ld_start = 1'b1;
        step();
        bus.ld_start = 1'b0;
        check_bit("load_busy", bus.busy, 1'b1);
        check_bit("load_ld_ready", bus.ld_ready, 1'b1);
    endtask

    // Directed sequence.
    initial begin
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
        bus.ld_data  = 8'h00;
        res = 1'b1;
        step();
        step();
        check_output("reset_dat_out", 16'(bus.dat_out), 16'h0000);
        check_bit("reset_dat_oe", bus.dat_oe, 1'b0);
        check_bit("reset_rd_valid", bus.rd_valid, 1'b0);
        check_bit("reset_ld_ready", bus.ld_ready, 1'b0);
        check_bit("reset_busy", bus.busy, 1'b0);
        check_bit("reset_bus_err", bus.bus_err, 1'b0);
        check_bit("reset_par_err", bus.par_err, 1'b0);
        res = 1'b0;
        step();

        // Program load of three words.
        start_load();
        load_word(8'h05, 1'b0);
        load_word(8'h06, 1'b0);
        load_word(8'h03, 1'b1);
        check_bit("load_done_busy", bus.busy, 1'b0);
        check_bit("load_done_ld_ready", bus.ld_ready, 1'b0);

        // Read latency, hold, and re-read on address change.
        apply_stimulus(1'b0, 1'b0, 1'b1, 8'h01, 8'h00);
        expect_read(8'h06);
        step();
        repeat (READ_LAT - 1) step();
        check_bit("rd_wait_dat_oe", bus.dat_oe, 1'b0);
        check_bit("rd_wait_rd_valid", bus.rd_valid, 1'b0);
        step();
        check_bit("rd_first_dat_oe", bus.dat_oe, 1'b1);
        check_bit("rd_first_rd_valid", bus.rd_valid, 1'b1);
        step();
        check_bit("rd_hold_dat_oe", bus.dat_oe, 1'b1);
        check_bit("rd_hold_rd_valid_pulse", bus.rd_valid, 1'b0);
        check_output("rd_hold_dat_out", 16'(bus.dat_out), 16'h0006);
        bus.adr = 8'h02;
        expect_read(8'h03);
        step();
        check_bit("adr_change_dat_oe", bus.dat_oe, 1'b0);
        repeat (READ_LAT) step();
        check_bit("adr_change_reread_dat_oe", bus.dat_oe, 1'b1);
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
        step();
        check_bit("rd_end_dat_oe", bus.dat_oe, 1'b0);

        // Single-cycle write followed immediately by a read of the same word.
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h02, 8'hFD);
        step();
        check_bit("write_dat_oe", bus.dat_oe, 1'b0);
        do_read(8'h02, 8'hFD, 1'b0);
        check_bit("write_no_bus_err", bus.bus_err, 1'b0);

        // Read and write strobes together: write wins, error is sticky.
        apply_stimulus(1'b0, 1'b0, 1'b0, 8'h10, 8'hAA);
        step();
        check_bit("conflict_dat_oe", bus.dat_oe, 1'b0);
        check_bit("conflict_rd_valid", bus.rd_valid, 1'b0);
        check_bit("conflict_bus_err", bus.bus_err, 1'b1);
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
        step();
        do_read(8'h10, 8'hAA, 1'b0);
        check_bit("conflict_bus_err_sticky", bus.bus_err, 1'b1);

        // Loader start request during a CPU read is ignored.
        do_read(8'h01, 8'h06, 1'b1);

        // Reset on the same edge as a write drops that write and clears bus_err.
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h20, 8'h11);
        step();
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
        step();
        apply_stimulus(1'b0, 1'b1, 1'b0, 8'h20, 8'h99);
        res = 1'b1;
        step();
        res = 1'b0;
        apply_stimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);
        check_bit("midreset_bus_err", bus.bus_err, 1'b0);
        check_bit("midreset_dat_oe", bus.dat_oe, 1'b0);
        step();
        do_read(8'h20, 8'h11, 1'b0);

        // Parity check on address 0.
`ifdef SUBLEQ_MEM_PARITY_EN
        dut.mem[0][0] = ~dut.mem[0][0];
        do_read(8'h00, 8'h04, 1'b0);
        check_bit("parity_err_set", bus.par_err, 1'b1);
`else
        do_read(8'h00, 8'h05, 1'b0);
        check_bit("parity_err_clear", bus.par_err, 1'b0);
`endif

        // Second load restarts at address 0.
        start_load();
        load_word(8'h77, 1'b1);
        check_bit("reload_busy", bus.busy, 1'b0);
        do_read(8'h00, 8'h77, 1'b0);
        do_read(8'h01, 8'h06, 1'b0);

        // Load of 257 words wraps the pointer back onto address 0.
        start_load();
        for (int i = 0; i <= 256; i++) begin
            load_word((i == 256) ? 8'hC3 : (8'(i) ^ 8'h5A), (i == 256));
        end
        check_bit("wrap_busy", bus.busy, 1'b0);
        do_read(8'h00, 8'hC3, 1'b0);
        do_read(8'h01, 8'h5B, 1'b0);
        do_read(8'hFF, 8'hA5, 1'b0);

        step();
        check_output("scoreboard_drained", 16'(exp_q.size()), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
